// File: rtl/pa_bank_sweep_sequencer_pkg.sv
// Shared widths, state encoding and config check for the PA bank sweep sequencer.
package pa_pkg;

  localparam int IDX_W     = 16;
  localparam int BANK_W    = 4;
  localparam int STG_W     = 8;
  localparam int CYC_W     = 12;
  localparam int NUM_BANKS = 16;
  localparam int ADDR_W    = IDX_W - BANK_W;
  localparam int TOT_W     = STG_W + CYC_W;

  localparam logic [TOT_W-1:0] MAX_TOTAL = TOT_W'(2 ** IDX_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A pass is legal only when it has at least one beat and fits the index space.
  function automatic logic cfg_legal(input logic [STG_W-1:0] num_stages,
                                     input logic [CYC_W-1:0] cyc_per_stage);
    logic [TOT_W-1:0] total;
    total = TOT_W'(num_stages) * TOT_W'(cyc_per_stage);
    return (total != '0) && (total <= MAX_TOTAL);
  endfunction

endpackage

// File: rtl/pa_bank_sweep_sequencer_counter.sv
// Nested cycle/stage counter plus the linear access index for one sweep pass.
module pa_stage_cycle_counter
  import pa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [STG_W-1:0] num_stages,
  input  logic [CYC_W-1:0] cyc_per_stage,
  output logic [IDX_W-1:0] index,
  output logic [STG_W-1:0] stage,
  output logic             stage_last,
  output logic             last
);

  logic [CYC_W-1:0] cycle;

  assign stage_last = (cycle == cyc_per_stage - CYC_W'(1));
  assign last       = stage_last && (stage == num_stages - STG_W'(1));

  // NOTE: every flop here uses non-blocking assignment so all counters update
  // from the same pre-edge values; the reset branch is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index <= '0;
      cycle <= '0;
      stage <= '0;
    end else if (clear) begin
      index <= '0;
      cycle <= '0;
      stage <= '0;
    end else if (en) begin
      // Index is a plain increment so non-power-of-2 stages never skip addresses.
      index <= index + IDX_W'(1);
      if (stage_last) begin
        cycle <= '0;
        stage <= stage + STG_W'(1);
      end else begin
        cycle <= cycle + CYC_W'(1);
      end
    end
  end

endmodule

// File: rtl/pa_bank_sweep_sequencer.sv
// Streams {stage, cycle} accesses to the 16-bank key/coefficient RAM, split mod-16 into bank/address.
module pa_bank_sweep_sequencer
  import pa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STG_W-1:0]  num_stages,
  input  logic [CYC_W-1:0]  cyc_per_stage,
  input  logic              abort,
  input  logic              acc_ready,
  output logic              acc_valid,
  output logic [BANK_W-1:0] acc_bank,
  output logic [ADDR_W-1:0] acc_addr,
  output logic [STG_W-1:0]  acc_stage,
  output logic              acc_stage_last,
  output logic              acc_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  state_e           state_q, state_d;
  logic [STG_W-1:0] ns_q;
  logic [CYC_W-1:0] cyc_q;
  logic             cfg_err_q;
  logic             start_ok, start_bad;
  logic             handshake, cnt_en;
  logic [IDX_W-1:0] index;
  logic [STG_W-1:0] stage;
  logic             stage_last, last;

  assign start_ok  = start && (state_q == ST_IDLE) &&  cfg_legal(num_stages, cyc_per_stage);
  assign start_bad = start && (state_q == ST_IDLE) && !cfg_legal(num_stages, cyc_per_stage);
  assign handshake = (state_q == ST_RUN) && acc_ready;
  // The final beat stays on the outputs, so the index never wraps past 0xFFFF.
  assign cnt_en    = handshake && !abort && !last;

  pa_stage_cycle_counter u_counter (
    .clk           (clk),
    .rst           (rst),
    .clear         (start_ok),
    .en            (cnt_en),
    .num_stages    (ns_q),
    .cyc_per_stage (cyc_q),
    .index         (index),
    .stage         (stage),
    .stage_last    (stage_last),
    .last          (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ns_q      <= '0;
      cyc_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= start_bad;
      if (start_ok) begin
        ns_q  <= num_stages;
        cyc_q <= cyc_per_stage;
      end
    end
  end

  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN: begin
        // Abort outranks a simultaneous final-beat handshake.
        if (abort)                  state_d = ST_IDLE;
        else if (handshake && last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        acc_valid = 1'b1;
        busy      = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign acc_bank       = index[BANK_W-1:0];
  assign acc_addr       = index[IDX_W-1:BANK_W];
  assign acc_stage      = stage;
  assign acc_stage_last = acc_valid && stage_last;
  assign acc_last       = acc_valid && last;
  assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_pa_bank_sweep_sequencer.sv
// Directed bench for pa_bank_sweep_sequencer: beat-index model checked every cycle plus literal pins.
module tb_pa_bank_sweep_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_stages;
  logic [11:0] cyc_per_stage;
  logic        abort;
  logic        acc_ready;
  logic        acc_valid;
  logic [3:0]  acc_bank;
  logic [11:0] acc_addr;
  logic [7:0]  acc_stage;
  logic        acc_stage_last;
  logic        acc_last;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  pa_bank_sweep_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_stages     (num_stages),
    .cyc_per_stage  (cyc_per_stage),
    .abort          (abort),
    .acc_ready      (acc_ready),
    .acc_valid      (acc_valid),
    .acc_bank       (acc_bank),
    .acc_addr       (acc_addr),
    .acc_stage      (acc_stage),
    .acc_stage_last (acc_stage_last),
    .acc_last       (acc_last),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {2'b0, acc_valid, acc_bank, acc_addr, acc_stage, acc_stage_last, acc_last,
            busy, done, cfg_err};
  endfunction

  // Model: a pass is a run of beats k = 0..total-1; every field is arithmetic on k.
  bit m_run, m_done, m_err, was_done;
  int m_k, m_total, m_cyc, tot;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_done = 0; m_err = 0; m_k = 0;
    end else begin
      was_done = m_done;
      m_done   = 0;
      m_err    = 0;
      if (m_run) begin
        if (abort) m_run = 0;
        else if (acc_ready) begin
          if (m_k == m_total - 1) begin m_run = 0; m_done = 1; end
          else m_k++;
        end
      end else if (!was_done && start) begin
        tot = int'(num_stages) * int'(cyc_per_stage);
        if (tot == 0 || tot > 65536) m_err = 1;
        else begin
          m_run = 1; m_k = 0; m_total = tot; m_cyc = int'(cyc_per_stage);
        end
      end
    end
  end

  logic [31:0] exp_v, act_v;
  always @(negedge clk) begin
    if (!rst) begin
      exp_v = {m_run, m_run || m_done, m_done, m_err, 28'b0};
      act_v = {acc_valid, busy, done, cfg_err, 28'b0};
      if (m_run) begin
        exp_v[25:0] = {4'(m_k % 16), 12'(m_k / 16), 8'(m_k / m_cyc),
                       (m_k % m_cyc) == m_cyc - 1, m_k == m_total - 1};
        act_v[25:0] = {acc_bank, acc_addr, acc_stage, acc_stage_last, acc_last};
      end
      check("cycle_model", act_v, exp_v);
    end
  end

  task automatic start_pass(input int ns, input int cyc);
    @(negedge clk);
    start = 1'b1; num_stages = 8'(ns); cyc_per_stage = 12'(cyc);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives acc_ready until done is seen or the bound expires; optionally pokes a start mid-run.
  task automatic run_pass(input int bound, input bit toggle, input int inject_at,
                          output int hs, output bit seen, output logic [31:0] last_beat);
    hs = 0; seen = 0; last_beat = '0;
    for (int i = 0; i < bound && !seen; i++) begin
      acc_ready = toggle ? (i % 2 == 0) : 1'b1;
      start     = (i == inject_at);
      if (i == inject_at) begin num_stages = 8'd5; cyc_per_stage = 12'd5; end
      if (acc_valid && acc_ready) begin
        hs++;
        if (acc_last) last_beat = {8'b0, acc_bank, acc_addr, acc_stage};
      end
      @(negedge clk);
      if (done) seen = 1;
    end
    start = 1'b0;
  endtask

  int          hs;
  bit          seen;
  logic [31:0] lb;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; acc_ready = 1'b0;
    num_stages = '0; cyc_per_stage = '0;
    @(negedge clk);
    check("reset_outputs", all_outs(), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 2 stages x 3 beats, always ready.
    acc_ready = 1'b1;
    start_pass(2, 3);
    check("t1_beat0", {acc_valid, acc_bank, acc_addr}, {1'b1, 4'h0, 12'h000});
    repeat (5) @(negedge clk);
    check("t1_beat5", {acc_bank, acc_addr, acc_stage, acc_stage_last, acc_last},
          {4'h5, 12'h000, 8'd1, 1'b1, 1'b1});
    @(negedge clk);
    check("t1_done", {done, busy, acc_valid}, 3'b110);
    @(negedge clk);
    check("t1_idle", {done, busy}, 2'b00);

    // 1 x 20 with ready toggling.
    start_pass(1, 20);
    hs = 0; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      acc_ready = (i % 2 == 0);
      if (acc_valid && acc_ready) begin
        if (hs >= 16 && hs <= 19)
          check("t2_beat_16_19", {acc_bank, acc_addr}, {4'(hs - 16), 12'h001});
        hs++;
      end
      @(negedge clk);
      if (done) seen = 1;
    end
    check("t2_done_seen", 32'(seen), 32'd1);
    check("t2_handshakes", hs, 20);

    // Illegal configurations.
    start_pass(0, 5);
    check("t3_zero_err", {cfg_err, acc_valid, busy}, 3'b100);
    @(negedge clk);
    check("t3_zero_pulse", {cfg_err, acc_valid, busy}, 3'b000);
    start_pass(255, 4095);
    check("t3_big_err", {cfg_err, acc_valid, busy}, 3'b100);
    start_pass(17, 4095);
    check("t3_over_err", {cfg_err, acc_valid, busy}, 3'b100);
    @(negedge clk);

    // Exactly 65536 beats: 32 stages x 2048.
    start_pass(32, 2048);
    run_pass(70000, 1'b0, -1, hs, seen, lb);
    check("t4_done_seen", 32'(seen), 32'd1);
    check("t4_handshakes", hs, 65536);
    check("t4_last_beat", lb, {8'b0, 4'hF, 12'hFFF, 8'd31});

    // Abort at beat 7 with ready high.
    acc_ready = 1'b1;
    start_pass(4, 10);
    repeat (7) @(negedge clk);
    check("t5a_beat7", {acc_bank, acc_addr}, {4'h7, 12'h000});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5a_abort", {acc_valid, busy, done}, 3'b000);
    @(negedge clk);
    check("t5a_no_done", {done, busy}, 2'b00);

    // Abort at beat 7 while stalled.
    start_pass(4, 10);
    repeat (7) @(negedge clk);
    acc_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5b_abort", {acc_valid, busy, done}, 3'b000);
    @(negedge clk);
    check("t5b_no_done", {done, busy}, 2'b00);
    start_pass(4, 10);
    check("t5_restart", {acc_valid, acc_bank, acc_addr, acc_stage}, {1'b1, 4'h0, 12'h000, 8'd0});
    run_pass(200, 1'b1, -1, hs, seen, lb);
    check("t5_restart_done", 32'(seen), 32'd1);
    check("t5_restart_hs", hs, 40);

    // Abort collides with the final-beat handshake.
    acc_ready = 1'b1;
    start_pass(1, 3);
    repeat (2) @(negedge clk);
    check("t5c_last", {acc_last, acc_stage_last}, 2'b11);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5c_abort_wins", {acc_valid, done, busy}, 3'b000);
    @(negedge clk);
    check("t5c_no_done", {done, busy}, 2'b00);

    // Async reset in the middle of a stall.
    start_pass(2, 10);
    repeat (3) @(negedge clk);
    acc_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("t6_rst_outputs", all_outs(), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    acc_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_residual", {acc_valid, busy, done}, 3'b000);

    // Start during RUN must not disturb the pass.
    start_pass(1, 12);
    run_pass(100, 1'b0, 3, hs, seen, lb);
    check("t6_done_seen", 32'(seen), 32'd1);
    check("t6_handshakes", hs, 12);
    check("t6_last_beat", lb, {8'b0, 4'hB, 12'h000, 8'd0});
    @(negedge clk);
    check("t6_idle", {acc_valid, busy, cfg_err}, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
